cfg_frame_parser: RTL
=====================

CFG_FRAME_PARSER -- requirements
Module: cfg_frame_parser

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 100000, meaning the idle clock cycles allowed between bytes of one frame (1 ms at 100 MHz).
REQ-002 SHALL have port clk, input, 1 bit: the single system clock (100 MHz); all logic is on the rising edge.
REQ-003 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port rx_data, input, 8 bits: received UART byte.
REQ-005 SHALL have port rx_valid, input, 1 bit: one-cycle strobe qualifying rx_data.
REQ-006 SHALL have ports delay_set_a, delay_set_b, delay_set_c and delay_set_d, each output, 16 bits: active per-channel output delays.
REQ-007 SHALL have port duty_cycle, output, 16 bits: active duty time.
REQ-008 SHALL have ports sub_clk_feq and sub_clk_scl, each output, 16 bits: active sub-clock divider settings.
REQ-009 SHALL have port cfg_update, output, 1 bit: one-cycle pulse in the cycle the active registers change.
REQ-010 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a rejected frame.
REQ-011 SHALL have port err_cnt, output, 8 bits: count of rejected frames.

Function
REQ-012 SHALL parse frames of 5 bytes: header 0xA5, ADDR, DHI, DLO, CSUM, where CSUM = ADDR ^ DHI ^ DLO.
REQ-013 SHALL implement states IDLE, ADDR, DHI, DLO and CSUM; each accepted byte advances one state, and CSUM returns to IDLE.
REQ-014 SHALL, in IDLE, silently ignore any byte other than 0xA5, with no error.
REQ-015 SHALL treat 0xA5 received after the header as an ordinary data byte (no resynchronisation).
REQ-016 SHALL, on a valid frame with ADDR 0x00–0x06, write {DHI,DLO} to the shadow register for delay_a, delay_b, delay_c, delay_d, duty_cycle, sub_clk_feq or sub_clk_scl respectively, in the cycle after the CSUM strobe.
REQ-017 SHALL treat a valid frame with ADDR 0x0F as COMMIT: all seven shadow registers are copied to the active outputs atomically one cycle after the CSUM strobe, with cfg_update high in that same cycle; DHI and DLO are ignored.
REQ-018 SHALL leave the active outputs unchanged by shadow writes until a COMMIT.
REQ-019 SHALL, on a checksum mismatch or an ADDR outside {0x00–0x06, 0x0F}, discard the frame, pulse frame_err one cycle after the CSUM strobe, and leave all registers unchanged.
REQ-020 SHALL clear the timeout counter on every rx_valid, and increment it on every other cycle while not in IDLE.
REQ-021 SHALL, when the timeout counter reaches TIMEOUT_CYC, go to IDLE, pulse frame_err and discard the partial frame.
REQ-022 SHALL let rx_valid take priority over timeout in the same cycle: the byte is accepted and no timeout occurs.
REQ-023 SHALL increment err_cnt on every frame_err pulse, saturating at 255 (no wrap).
REQ-024 SHALL ignore a repeated COMMIT with unchanged shadows except for issuing the cfg_update pulse again.

Reset
REQ-025 SHALL, while rstn is low, force: state IDLE; timeout counter 0; cfg_update, frame_err and err_cnt 0.
REQ-026 SHALL, while rstn is low, force all shadow and active registers to 0x0000, except sub_clk_feq = 100 and sub_clk_scl = 1 (no zero divider downstream).
REQ-027 SHALL, on reset asserted mid-frame, drop the partial frame with no frame_err pulse.

Structure
REQ-028 SHALL place in a shared package abcd_cfg_pkg: the header constant 0xA5, the address constants 0x00–0x06 and 0x0F, the state enumeration, and the register reset values.
REQ-029 SHALL be a single module with no sub-module; the checksum is inline XOR.

Verification
REQ-030 SHALL verify basic write and commit: send A5 00 01 F4 F5, then A5 0F 00 00 0F -> delay_set_a = 0x01F4 only after the commit, with cfg_update high for 1 cycle and other outputs at their reset values.
REQ-031 SHALL verify checksum error: send A5 04 12 34 00 -> frame_err pulse, err_cnt = 1; a following commit leaves duty_cycle = 0.
REQ-032 SHALL verify timeout: send A5 02, then wait TIMEOUT_CYC cycles -> frame_err; the next frame A5 02 00 0A 08 is accepted normally.
REQ-033 SHALL verify garbage before the header: send 11 22 A5 06 00 05 03, then commit -> sub_clk_scl = 5, with no error.
REQ-034 SHALL verify saturation: send 300 bad frames -> err_cnt = 255.
REQ-035 SHALL verify reset mid-frame: assert rstn low after A5 01 -> all outputs at their reset values, err_cnt = 0, and the parser is in IDLE.

Source files
------------

// File: rtl/abcd_cfg_pkg.sv
// Shared definitions for the configuration frame parser: frame header,
// register addresses, parser state encoding and register reset values.
package abcd_cfg_pkg;

    // Frame header byte that starts every frame.
    localparam logic [7:0] HDR_BYTE = 8'hA5;

    // Number of configuration registers in each bank (shadow and active).
    localparam int NUM_REGS = 7;

    // Bank slot of each register; also its frame address.
    localparam int IDX_DELAY_A     = 0;
    localparam int IDX_DELAY_B     = 1;
    localparam int IDX_DELAY_C     = 2;
    localparam int IDX_DELAY_D     = 3;
    localparam int IDX_DUTY_CYCLE  = 4;
    localparam int IDX_SUB_CLK_FEQ = 5;
    localparam int IDX_SUB_CLK_SCL = 6;

    // Frame addresses.
    localparam logic [7:0] ADDR_DELAY_A     = 8'(IDX_DELAY_A);
    localparam logic [7:0] ADDR_DELAY_B     = 8'(IDX_DELAY_B);
    localparam logic [7:0] ADDR_DELAY_C     = 8'(IDX_DELAY_C);
    localparam logic [7:0] ADDR_DELAY_D     = 8'(IDX_DELAY_D);
    localparam logic [7:0] ADDR_DUTY_CYCLE  = 8'(IDX_DUTY_CYCLE);
    localparam logic [7:0] ADDR_SUB_CLK_FEQ = 8'(IDX_SUB_CLK_FEQ);
    localparam logic [7:0] ADDR_SUB_CLK_SCL = 8'(IDX_SUB_CLK_SCL);
    localparam logic [7:0] ADDR_COMMIT      = 8'h0F;

    // Parser states: each names the byte the parser is waiting for.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DHI,
        ST_DLO,
        ST_CSUM
    } state_e;

    // One bank of configuration registers, slot 0 in the low bits.
    typedef logic [NUM_REGS-1:0][15:0] cfg_bank_t;

    // Dividers reset to non-zero values so downstream clocks never divide by 0.
    localparam logic [15:0] RST_DELAY      = 16'h0000;
    localparam logic [15:0] RST_DUTY_CYCLE = 16'h0000;
    localparam logic [15:0] RST_SUB_CLK_FEQ = 16'd100;
    localparam logic [15:0] RST_SUB_CLK_SCL = 16'd1;

    localparam cfg_bank_t CFG_RST = {
        RST_SUB_CLK_SCL,
        RST_SUB_CLK_FEQ,
        RST_DUTY_CYCLE,
        RST_DELAY,
        RST_DELAY,
        RST_DELAY,
        RST_DELAY
    };

    // True for addresses that name a writable shadow register.
    function automatic logic is_reg_addr(input logic [7:0] addr);
        return addr <= ADDR_SUB_CLK_SCL;
    endfunction

endpackage

// File: rtl/cfg_frame_parser.sv
// Configuration frame parser. Receives 5-byte frames (A5, ADDR, DHI, DLO,
// CSUM) from a UART byte stream, writes a shadow register bank, and copies the
// shadow bank to the active outputs atomically on a COMMIT frame. Malformed
// frames and inter-byte timeouts are rejected and counted.
module cfg_frame_parser
    import abcd_cfg_pkg::*;
#(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [15:0] delay_set_a,
    output logic [15:0] delay_set_b,
    output logic [15:0] delay_set_c,
    output logic [15:0] delay_set_d,
    output logic [15:0] duty_cycle,
    output logic [15:0] sub_clk_feq,
    output logic [15:0] sub_clk_scl,
    output logic        cfg_update,
    output logic        frame_err,
    output logic [7:0]  err_cnt
);

    // The counter must be able to hold TIMEOUT_CYC itself.
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYC);

    state_e            state_q,      state_d;
    logic [TMO_W-1:0]  tmo_cnt_q,    tmo_cnt_d;
    logic [7:0]        addr_q,       addr_d;
    logic [7:0]        dhi_q,        dhi_d;
    logic [7:0]        dlo_q,        dlo_d;
    cfg_bank_t         shadow_q,     shadow_d;
    cfg_bank_t         active_q,     active_d;
    logic              cfg_update_q, cfg_update_d;
    logic              frame_err_q,  frame_err_d;
    logic [7:0]        err_cnt_q,    err_cnt_d;

    // Checksum expected for the frame currently being assembled.
    logic [7:0] csum_exp;
    assign csum_exp = addr_q ^ dhi_q ^ dlo_q;

    // Next-state logic: byte parsing, frame evaluation, timeout and error count.
    always_comb begin
        // NOTE: every _d takes its _q value first, so any path that does not
        // assign it holds state instead of inferring a latch.
        state_d      = state_q;
        tmo_cnt_d    = tmo_cnt_q;
        addr_d       = addr_q;
        dhi_d        = dhi_q;
        dlo_d        = dlo_q;
        shadow_d     = shadow_q;
        active_d     = active_q;
        cfg_update_d = 1'b0;
        frame_err_d  = 1'b0;
        err_cnt_d    = err_cnt_q;

        if (rx_valid) begin
            // A received byte always restarts the inter-byte timer, even when
            // the timer would have expired in this same cycle.
            tmo_cnt_d = '0;
            unique case (state_q)
                ST_IDLE: begin
                    // Anything other than the header is line noise; drop it.
                    if (rx_data == HDR_BYTE) begin
                        state_d = ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    addr_d  = rx_data;
                    state_d = ST_DHI;
                end
                ST_DHI: begin
                    dhi_d   = rx_data;
                    state_d = ST_DLO;
                end
                ST_DLO: begin
                    dlo_d   = rx_data;
                    state_d = ST_CSUM;
                end
                ST_CSUM: begin
                    state_d = ST_IDLE;
                    if (rx_data != csum_exp) begin
                        frame_err_d = 1'b1;
                    end else if (addr_q == ADDR_COMMIT) begin
                        // Whole bank moves at once; payload bytes are ignored.
                        active_d     = shadow_q;
                        cfg_update_d = 1'b1;
                    end else if (is_reg_addr(addr_q)) begin
                        shadow_d[addr_q[2:0]] = {dhi_q, dlo_q};
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (state_q != ST_IDLE) begin
            // Mid-frame silence: count it, and abandon the frame at the limit.
            if (tmo_cnt_q == TMO_LIMIT) begin
                state_d     = ST_IDLE;
                tmo_cnt_d   = '0;
                frame_err_d = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
        end

        // Error counter saturates so a flood of bad frames stays visible.
        if (frame_err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // State, register banks and registered output pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            tmo_cnt_q    <= '0;
            addr_q       <= '0;
            dhi_q        <= '0;
            dlo_q        <= '0;
            // NOTE: both banks are reset, not left to power-up contents, so
            // the dividers downstream never see zero.
            shadow_q     <= CFG_RST;
            active_q     <= CFG_RST;
            cfg_update_q <= 1'b0;
            frame_err_q  <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values computed above, independent of statement order.
            state_q      <= state_d;
            tmo_cnt_q    <= tmo_cnt_d;
            addr_q       <= addr_d;
            dhi_q        <= dhi_d;
            dlo_q        <= dlo_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            cfg_update_q <= cfg_update_d;
            frame_err_q  <= frame_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign delay_set_a = active_q[IDX_DELAY_A];
    assign delay_set_b = active_q[IDX_DELAY_B];
    assign delay_set_c = active_q[IDX_DELAY_C];
    assign delay_set_d = active_q[IDX_DELAY_D];
    assign duty_cycle  = active_q[IDX_DUTY_CYCLE];
    assign sub_clk_feq = active_q[IDX_SUB_CLK_FEQ];
    assign sub_clk_scl = active_q[IDX_SUB_CLK_SCL];
    assign cfg_update  = cfg_update_q;
    assign frame_err   = frame_err_q;
    assign err_cnt     = err_cnt_q;

endmodule
